// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment display controller.
// Backpressure: none; pure declarations.
package seg_pkg;

   typedef enum logic [1:0] {
      S_PAT,
      S_VAL,
      S_GAP
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low {a,b,c,d,e,f,g,dp}; the decimal point stays dark.
   function automatic logic [7:0] hexdec(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0:    s = 8'h03;
         4'h1:    s = 8'h9F;
         4'h2:    s = 8'h25;
         4'h3:    s = 8'h0D;
         4'h4:    s = 8'h99;
         4'h5:    s = 8'h49;
         4'h6:    s = 8'h41;
         4'h7:    s = 8'h1F;
         4'h8:    s = 8'h01;
         4'h9:    s = 8'h09;
         4'hA:    s = 8'h11;
         4'hB:    s = 8'hC1;
         4'hC:    s = 8'h63;
         4'hD:    s = 8'h85;
         4'hE:    s = 8'h61;
         default: s = 8'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Display controller bundle: value strobe, pattern inputs and pin outputs.
// Backpressure: none; strobes and levels only.
interface seg_display_ctrl_if;
   logic [15:0] value;
   logic        value_vld;
   logic        pause;
   logic [7:0]  pat_seg;
   logic [3:0]  pat_an;
   logic        step_en;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        mode;

   modport master (
      output value, value_vld, pause, pat_seg, pat_an,
      input  step_en, seg, an, mode
   );

   modport slave (
      input  value, value_vld, pause, pat_seg, pat_an,
      output step_en, seg, an, mode
   );
endinterface

// File: rtl/clk_en_div.sv
// Free-running divider giving a one-cycle tick every DIV clocks; tick is combinational.
// Backpressure: none; counts regardless of downstream state.
module clk_en_div #(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end
endmodule

// File: rtl/seg_display_ctrl.sv
// Shares the 4-digit display between the chase pattern and a held hex value; outputs 1-cycle registered.
// Backpressure: none; value_vld is always accepted and pattern stepping is gated instead.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV   = 100000,
   parameter int STEP_DIV   = 10000000,
   parameter int HOLD_STEPS = 20
) (
   input  logic                CLK,
   input  logic                RST,
   seg_display_ctrl_if.slave   bus
);
   localparam int HW = $clog2(HOLD_STEPS + 1);

   logic          step_tick;
   logic          scan_tick;
   logic [1:0]    digit;
   logic [HW-1:0] hold_cnt;
   logic [15:0]   value_q;
   state_t        state;

   logic          step_en_q;
   logic [7:0]    seg_q;
   logic [3:0]    an_q;
   logic          mode_q;

   clk_en_div #(.DIV(STEP_DIV)) u_step_div (
      .CLK  (CLK),
      .RST  (RST),
      .tick (step_tick)
   );

   clk_en_div #(.DIV(SCAN_DIV)) u_scan_div (
      .CLK  (CLK),
      .RST  (RST),
      .tick (scan_tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         digit <= '0;
      end else if (scan_tick) begin
         digit <= digit + 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_PAT;
         hold_cnt  <= '0;
         value_q   <= '0;
         step_en_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= AN_OFF;
         mode_q    <= 1'b0;
      end else begin
         step_en_q <= step_tick & ~bus.pause & (state == S_PAT);
         mode_q    <= (state != S_PAT);

         case (state)
            S_PAT: begin
               seg_q <= bus.pat_seg;
               an_q  <= bus.pat_an;
            end
            S_VAL: begin
               seg_q <= hexdec(value_q[{digit, 2'b00} +: 4]);
               an_q  <= ~(4'b0001 << digit);
            end
            default: begin
               seg_q <= SEG_BLANK;
               an_q  <= AN_OFF;
            end
         endcase

         // A new value always restarts the hold, even on a tick.
         if (bus.value_vld) begin
            value_q  <= bus.value;
            state    <= S_VAL;
            hold_cnt <= HW'(HOLD_STEPS);
         end else if (step_tick) begin
            case (state)
               S_VAL: begin
                  if (hold_cnt == HW'(1)) begin
                     state <= S_GAP;
                  end else begin
                     hold_cnt <= hold_cnt - HW'(1);
                  end
               end
               S_GAP:   state <= S_PAT;
               default: state <= state;
            endcase
         end
      end
   end

   assign bus.step_en = step_en_q;
   assign bus.seg     = seg_q;
   assign bus.an      = an_q;
   assign bus.mode    = mode_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Checks seg_display_ctrl cycle by cycle against a reference model built from the display rules.
module tb_seg_display_ctrl;
   localparam int SCAN_DIV   = 4;
   localparam int STEP_DIV   = 8;
   localparam int HOLD_STEPS = 3;

   localparam logic [7:0] HEX_TAB [16] = '{
      8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
   localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg_display_ctrl_if bus ();

   seg_display_ctrl #(
      .SCAN_DIV   (SCAN_DIV),
      .STEP_DIV   (STEP_DIV),
      .HOLD_STEPS (HOLD_STEPS)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Model: what is on screen (0 pattern, 1 value, 2 gap), ticks left, latched value, cycles since reset.
   int          m_show;
   int          m_left;
   logic [15:0] m_val;
   int          n;
   int          step_pulses;

   logic [7:0] e_seg;
   logic [3:0] e_an;
   logic       e_mode;
   logic       e_step;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic model_edge();
      bit tick;
      int d;
      if (rst) begin
         e_seg  = 8'hFF;
         e_an   = 4'hF;
         e_mode = 1'b0;
         e_step = 1'b0;
         m_show = 0;
         m_left = 0;
         m_val  = 16'h0000;
         n      = 0;
      end else begin
         tick   = ((n % STEP_DIV) == STEP_DIV - 1);
         d      = (n / SCAN_DIV) % 4;
         e_step = tick && !bus.pause && (m_show == 0);
         e_mode = (m_show != 0);
         if (m_show == 0) begin
            e_seg = bus.pat_seg;
            e_an  = bus.pat_an;
         end else if (m_show == 1) begin
            e_seg = HEX_TAB[m_val[4*d +: 4]];
            e_an  = AN_TAB[d];
         end else begin
            e_seg = 8'hFF;
            e_an  = 4'hF;
         end
         if (bus.value_vld) begin
            m_show = 1;
            m_left = HOLD_STEPS;
            m_val  = bus.value;
         end else if (tick) begin
            if (m_show == 1) begin
               m_left--;
               if (m_left == 0) m_show = 2;
            end else if (m_show == 2) begin
               m_show = 0;
            end
         end
         n++;
      end
   endtask

   task automatic cyc();
      bus.pat_seg = 8'($urandom);
      bus.pat_an  = 4'($urandom);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("seg", 16'(bus.seg), 16'(e_seg));
      chk("an", 16'(bus.an), 16'(e_an));
      chk("mode", 16'(bus.mode), 16'(e_mode));
      chk("step_en", 16'(bus.step_en), 16'(e_step));
      if (bus.step_en === 1'b1) step_pulses++;
   endtask

   task automatic strobe(input logic [15:0] v);
      bus.value     = v;
      bus.value_vld = 1'b1;
      cyc();
      bus.value_vld = 1'b0;
   endtask

   initial begin
      int k;
      bus.value     = 16'hFFFF;
      bus.value_vld = 1'b1;
      bus.pause     = 1'b0;
      bus.pat_seg   = 8'h00;
      bus.pat_an    = 4'h0;
      step_pulses   = 0;

      // Reset dominates a simultaneous strobe.
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      bus.value_vld = 1'b0;

      step_pulses = 0;
      repeat (32) cyc();
      chk("free_pulses", 16'(step_pulses), 16'd4);

      bus.pause   = 1'b1;
      step_pulses = 0;
      repeat (24) cyc();
      chk("paused_pulses", 16'(step_pulses), 16'd0);
      bus.pause   = 1'b0;
      step_pulses = 0;
      repeat (16) cyc();
      chk("resumed_pulses", 16'(step_pulses), 16'd2);

      // Value display, hold, gap and return to the pattern.
      strobe(16'h1A50);
      step_pulses = 0;
      k = 0;
      while (m_show != 0 && k < 200) begin
         cyc();
         k++;
      end
      chk("val_return_bound", 16'(k < 200), 16'd1);
      chk("val_pulses", 16'(step_pulses), 16'd0);
      repeat (16) cyc();

      // Strobe landing exactly on the final hold tick.
      strobe(16'h3C7E);
      k = 0;
      while (!(m_show == 1 && m_left == 1 && (n % STEP_DIV) == STEP_DIV - 1) && k < 100) begin
         cyc();
         k++;
      end
      chk("align_bound", 16'(k < 100), 16'd1);
      strobe(16'hB4D2);
      k = 0;
      while (bus.mode === 1'b1 && k < 100) begin
         cyc();
         k++;
      end
      // Three full hold periods plus one gap period after a strobe on a tick.
      chk("reload_mode_cycles", 16'(k), 16'(4 * STEP_DIV + 1));

      // Strobe during the blank gap.
      strobe(16'h0F96);
      k = 0;
      while (m_show != 2 && k < 100) begin
         cyc();
         k++;
      end
      chk("gap_bound", 16'(k < 100), 16'd1);
      strobe(16'hE8D1);
      repeat (40) cyc();

      // Reset in the middle of a value display.
      strobe(16'h5A5A);
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (40) cyc();

      for (int i = 0; i < 400; i++) begin
         bus.pause = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 29) == 0) begin
            bus.value     = 16'($urandom);
            bus.value_vld = 1'b1;
         end
         cyc();
         bus.value_vld = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Controller that sequences the segment-chase pattern sequencer and shares the 4-digit seven-segment display between two sources:
- the chase pattern (pat_seg/pat_an);
- a 16-bit hex value shown on all four digits.

It generates the pattern's step enable, runs a time-multiplexed digit scan for value display, and holds the value on screen for a programmable time before a blank gap and return to the pattern. It sits between the pattern sequencer and the board seg/an pins.

Parameters:
SCAN_DIV, 100000, CLK cycles per digit during value scan (>=2)
STEP_DIV, 10000000, CLK cycles per animation step tick (>=2)
HOLD_STEPS, 20, step ticks the value stays displayed (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
value  in  16  hex value to show; digit d shows value[4d+3:4d]
value_vld  in  1  one-cycle strobe: latch value and take the display
pause  in  1  level; freezes pattern stepping (hold timing unaffected)
pat_seg  in  8  segment drive from pattern sequencer, active-low
pat_an  in  4  anode drive from pattern sequencer, active-low
step_en  out  1  one-cycle enable that advances the pattern sequencer
seg  out  8  display segments, active-low, {a,b,c,d,e,f,g,dp}
an  out  4  display anodes, active-low, digit0 = 4'b1110
mode  out  1  0 = pattern shown, 1 = value or gap shown

Behaviour:
- One clock (CLK); synchronous active-high RST, which overrides every other input in the same cycle.
- Reset values:
  - outputs: seg=8'hFF, an=4'hF, step_en=0, mode=0;
  - state: FSM=S_PAT, all counters 0, value register 0.
- Step divider:
  - step_cnt counts 0..STEP_DIV-1 and wraps.
  - tick is high for the cycle in which step_cnt==STEP_DIV-1.
  - Free-running; not affected by pause or state.
- Scan divider:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, the 2-bit digit index advances 0->1->2->3->0.
  - Free-running in all states.
- step_en (registered) is the previous cycle's (tick & ~pause & state==S_PAT). Pattern is frozen while paused or while the value/gap is shown.
- FSM (registered) states are S_PAT, S_VAL and S_GAP.
  - S_PAT: value_vld -> S_VAL; load hold_cnt=HOLD_STEPS.
  - S_VAL: each tick decrements hold_cnt. On a tick with hold_cnt==1 -> S_GAP. value_vld reloads hold_cnt=HOLD_STEPS and stays in S_VAL.
  - S_GAP: lasts until the next tick, then -> S_PAT. value_vld -> S_VAL with reload.
  - value_vld coincident with a tick always wins (reload, S_VAL); the tick does not decrement.
  - value is latched on every value_vld, in any state.
- Output mux, registered with 1-cycle latency from the state/inputs:
  - S_PAT: seg=pat_seg, an=pat_an.
  - S_VAL: an=~(4'b0001<<digit), seg=hexdec(nibble[digit]).
  - S_GAP: seg=8'hFF, an=4'hF.
  - mode=0 in S_PAT, 1 otherwise.
- hexdec: active-low, dp always 1. Values include:
  - 0=8'h03, 1=8'h9F, 2=8'h25, 3=8'h0D, 4=8'h99, 5=8'h49, 6=8'h41, 7=8'h1F
  - 8=8'h01, 9=8'h09, A=8'h11, b=8'hC1, C=8'h63, d=8'h85, E=8'h61, F=8'h71
- Counter widths: $clog2 of the parameter; hold_cnt is $clog2(HOLD_STEPS+1). No overflow is possible.

Decomposition:
- Package seg_pkg holds:
  - the FSM state enum;
  - constants SEG_BLANK=8'hFF, AN_OFF=4'hF;
  - a hexdec function (4-bit in -> 8-bit active-low seg).
- Sub-module clk_en_div (parameter DIV; ports CLK, RST, tick) produces the one-cycle tick. It is instantiated for the step and scan dividers; the scan divider's tick advances the digit index.

Test Plan:
Bench uses SCAN_DIV=4, STEP_DIV=8, HOLD_STEPS=3.
- Reset: hold RST 3 cycles with value_vld=1 -> seg=FF, an=F, mode=0, step_en=0 throughout. After release, step_en pulses once every 8 cycles, first pulse 8 cycles after release (tick at cycle 7 + 1 register).
- pause=1 for 24 cycles -> step_en never pulses. pause=0 -> pulses resume on the original 8-cycle grid.
- value=16'h1A50 strobed in S_PAT -> mode=1 and the scan shows:
  - an=1110/seg=03
  - an=1101/seg=49
  - an=1011/seg=11
  - an=0111/seg=9F
  - each digit for 4 cycles; step_en stays 0.
- Same run, no further strobes -> after the 3rd tick, seg=FF/an=F for 8 cycles. Then mode=0 and seg/an equal pat_seg/pat_an delayed by 1 cycle.
- value_vld coincident with the final hold tick -> stays in S_VAL with hold reloaded to 3 (3 more ticks before the gap). value_vld during S_GAP -> back to S_VAL showing the new value.
- RST asserted mid-S_VAL -> next cycle seg=FF, an=F, mode=0, step_en=0. After release, mode stays 0 and the latched value is cleared to 0.
